multiword_add_sequencer: RTL and testbench
==========================================

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 SHALL have parameter N_WORDS, default 4, the number of 16-bit words per operand (2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port sub, input, 1 bit: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port abort, input, 1 bit: cancels an operation in RUN.
REQ-007 SHALL have port a, input, 16*N_WORDS bits: operand A, sampled with start.
REQ-008 SHALL have port b, input, 16*N_WORDS bits: operand B, sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port sum, output, 16*N_WORDS bits: result.
REQ-012 SHALL have port cout, output, 1 bit: final carry out; for subtraction, 1 means no borrow.
REQ-013 SHALL have port ovf, output, 1 bit: signed two's-complement overflow.

Function
REQ-014 SHALL use exactly one instance of sixteen_bit_carry_lookahead_adder as its only adder, time-shared across words; no other add logic is permitted.
REQ-015 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-016 SHALL, in IDLE with start=1, latch a, b and sub, set the word index to 0, set the carry register to sub, and go to RUN; start=0 stays in IDLE.
REQ-017 SHALL, in each RUN cycle, drive the adder with:
- A input = word[idx] of latched A;
- B input = word[idx] of latched B XOR {16{sub}};
- Cin = the carry register.
REQ-018 SHALL, in each RUN cycle, store the adder S output into accumulator word[idx], load the carry register from Cout, and increment idx.
REQ-019 SHALL, on the RUN cycle with idx = N_WORDS-1:
- compute ovf = (A_msb == Beff_msb) AND (S_msb != A_msb), where Beff is the inverted-if-sub B;
- go to DONE.
REQ-020 SHALL, on entry to DONE, load sum, cout and ovf from the accumulator and carry register in the same edge.
REQ-021 SHALL drive done high for exactly the one DONE cycle and then return to IDLE.
REQ-022 SHALL hold sum, cout and ovf stable from the DONE cycle until the next DONE cycle or reset.
REQ-023 SHALL therefore assert done on the (N_WORDS+1)th rising edge after the edge that sampled start; with N_WORDS=4, done is high during the 5th cycle.
REQ-024 SHALL ignore start while busy=1, including during the DONE cycle; a new start is accepted no earlier than the first IDLE cycle after done.
REQ-025 SHALL, on abort=1 in RUN, go to IDLE at the next edge:
- done is not asserted;
- sum, cout and ovf keep their previous values;
- the partial accumulator is discarded.
REQ-026 SHALL ignore abort in IDLE and DONE.
REQ-027 SHALL give abort priority over completion when abort=1 on the last RUN cycle.
REQ-028 SHALL perform all arithmetic modulo 2^(16*N_WORDS), with the carry propagating word 0 (LSW) to word N_WORDS-1 (MSW).

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, set all of the following regardless of state, including mid-RUN: state=IDLE, idx=0, carry=0, accumulator=0, sum=0, cout=0, ovf=0, done=0, busy=0.
REQ-030 SHALL ignore start and abort on any edge where rst_n=0.

Verification (N_WORDS=4)
REQ-031 Add wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, sub=0 -> done on the 5th edge, sum=0, cout=1, ovf=0, busy high for 4 RUN cycles plus the DONE cycle.
REQ-032 Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, sub=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-033 Subtract with borrow: A=0x5, B=0x7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; then A=0x7, B=0x5, sub=1 -> sum=0x2, cout=1.
REQ-034 Busy/abort: start pulsed again during RUN -> ignored, single done; start, then abort on the 2nd RUN cycle -> busy low next cycle, no done, sum holds the prior result.
REQ-035 Reset mid-operation: rst_n=0 during the 3rd RUN cycle -> next edge sum=0, cout=0, ovf=0, busy=0, done=0; a subsequent start completes normally.
REQ-036 Back-to-back: start held high continuously -> operations accepted every 6 cycles (IDLE, 4xRUN, DONE), each with correct results.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Multiword add/subtract: one 16-bit CLA is reused word by word, LSW first, with the carry held in a register.
// Latency: done is high N_WORDS+1 cycles after the start edge (N_WORDS RUN cycles, then one DONE cycle).
// Backpressure: start is accepted only in IDLE and ignored while busy; abort in RUN returns to IDLE with no done.

module sixteen_bit_carry_lookahead_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_s,
  output logic        o_cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;
  logic [15:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Group generate/propagate for each 4-bit block
  always_comb begin
    w_gg = '0;
    w_gp = '0;
    for (int k = 0; k < 4; k++) begin
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k] = &w_p[4*k +: 4];
    end
  end

  // Second-level lookahead: block carries in from the group terms directly
  always_comb begin
    w_gc    = '0;
    w_gc[0] = i_cin;
    w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
    w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
            | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
  end

  // Bit carries inside each block, seeded by the block carry-in
  always_comb begin
    w_c = '0;
    for (int k = 0; k < 4; k++) begin
      w_c[4*k] = w_gc[k];
      for (int j = 1; j < 4; j++) begin
        w_c[4*k+j] = w_g[4*k+j-1] | (w_p[4*k+j-1] & w_c[4*k+j-1]);
      end
    end
  end

  assign o_s    = w_p ^ w_c;
  assign o_cout = w_gc[4];

endmodule

module multiword_add_sequencer #(
  parameter int N_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  abort,
  input  logic [16*N_WORDS-1:0] a,
  input  logic [16*N_WORDS-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [16*N_WORDS-1:0] sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W    = 16 * N_WORDS;
  localparam int IDXW = $clog2(N_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_sub;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [15:0]     w_a_word;
  logic [15:0]     w_b_word;
  logic [15:0]     w_s;
  logic            w_cout;
  logic            w_last;
  logic            w_ovf;
  logic [W-1:0]    w_acc_next;

  assign w_a_word = r_a[r_idx*16 +: 16];
  assign w_b_word = r_b[r_idx*16 +: 16] ^ {16{r_sub}};
  assign w_last   = (r_idx == IDXW'(N_WORDS - 1));
  // Only meaningful on the MSW cycle, where the word bits are the operand sign bits
  assign w_ovf    = (w_a_word[15] == w_b_word[15]) && (w_s[15] != w_a_word[15]);

  sixteen_bit_carry_lookahead_adder u_cla (
    .i_a    (w_a_word),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // Accumulator with the current word replaced by this cycle's adder output
  always_comb begin
    w_acc_next                  = r_acc;
    w_acc_next[r_idx*16 +: 16]  = w_s;
  end

  // Sequencer FSM, operand/accumulator registers and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_idx   <= '0;
            r_carry <= sub;
            r_acc   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort wins even on the last word; results stay at the previous op
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_acc   <= w_acc_next;
            r_carry <= w_cout;
            r_idx   <= r_idx + IDXW'(1);
            if (w_last) begin
              // Final word is folded in directly so results land on the DONE entry edge
              r_sum   <= w_acc_next;
              r_cout  <= w_cout;
              r_ovf   <= w_ovf;
              r_idx   <= '0;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer at N_WORDS=4: directed table, random ops against a 64-bit arithmetic model,
// and hand sequences for abort, reset mid-op, start while busy and back-to-back operation.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_multiword_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        abort;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.N_WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .abort (abort),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: plain 65-bit arithmetic on whole operands
  task automatic model(input logic [63:0] ma, input logic [63:0] mb, input logic ms,
                       output logic [63:0] msum, output logic mco, output logic mov);
    logic [63:0] beff;
    logic [64:0] t;
    beff = ms ? ~mb : mb;
    t    = {1'b0, ma} + {1'b0, beff} + {64'd0, ms};
    msum = t[63:0];
    mco  = t[64];
    mov  = (ma[63] == beff[63]) && (msum[63] != ma[63]);
  endtask

  // Issue one op from an IDLE falling edge and check latency, busy, results and the one-cycle done
  task automatic run_op(input logic [63:0] oa, input logic [63:0] ob, input logic os,
                        input logic [63:0] esum, input logic eco, input logic eov, input string tag);
    int c;
    bit busy_ok;
    a = oa; b = ob; sub = os; start = 1'b1;
    c = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      c++;
      if (!busy) busy_ok = 1'b0;
    end while (!done && c < 20);
    chk({tag, "_latency"}, 64'(c), 64'd5);
    chk({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_cout"}, {63'd0, cout}, {63'd0, eco});
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eov});
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [63:0] msum;
    logic        mco;
    logic        mov;
    logic [63:0] prior;
    logic [63:0] ba[4];
    logic [63:0] bb[4];
    logic        bs[4];
    int          c;
    int          ndone;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; abort = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
             $sformatf("vec%0d", i));
    end

    // Random ops against the model, with word-boundary-heavy operands mixed in
    for (int i = 0; i < 30; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rs;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 3 == 0) ra = ra | 64'hFFFF_0000_FFFF_0000;
      if (i % 4 == 1) rb = ~ra;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, msum, mco, mov);
      run_op(ra, rb, rs, msum, mco, mov, $sformatf("rnd%0d", i));
    end

    // Start pulsed during RUN and during DONE is ignored: exactly one done
    prior = sum;
    model(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, msum, mco, mov);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; sub = 1'b0; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = (k == 2 || k == 5) ? 1'b1 : 1'b0;
      if (k == 2) begin a = '0; b = '0; end
      if (done) ndone++;
      if (k == 5) chk("busy_start_done_cycle", {63'd0, done}, 64'd1);
      if (k == 6) chk("busy_start_idle_after", {63'd0, busy}, 64'd0);
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_sum", sum, msum);

    // Abort on the 2nd RUN cycle
    prior = sum;
    a = 64'hDEAD_BEEF_0000_0001; b = 64'h1; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort2_busy", {63'd0, busy}, 64'd0);
    chk("abort2_done", {63'd0, done}, 64'd0);
    chk("abort2_sum", sum, prior);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort2_no_done", 64'(ndone), 64'd0);

    // Abort on the last RUN cycle beats completion
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_last_busy", {63'd0, busy}, 64'd0);
    chk("abort_last_done", {63'd0, done}, 64'd0);
    chk("abort_last_sum", sum, prior);
    chk("abort_last_cout", {63'd0, cout}, {63'd0, mco});
    @(negedge clk);

    // Reset during the 3rd RUN cycle, with start and abort asserted on the reset edge
    a = 64'h0123_4567_89AB_CDEF; b = 64'h1; sub = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0; start = 1'b1; abort = 1'b1;
    @(negedge clk); rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    chk("rstmid_sum", sum, 64'd0);
    chk("rstmid_cout", {63'd0, cout}, 64'd0);
    chk("rstmid_ovf", {63'd0, ovf}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_done", {63'd0, done}, 64'd0);
    model(64'h0123_4567_89AB_CDEF, 64'h1, 1'b1, msum, mco, mov);
    run_op(64'h0123_4567_89AB_CDEF, 64'h1, 1'b1, msum, mco, mov, "after_rst");

    // Start held high: an op every 6 cycles, operands changed during each DONE cycle
    for (int k = 0; k < 4; k++) begin
      ba[k] = {$urandom, $urandom};
      bb[k] = {$urandom, $urandom};
      bs[k] = 1'(k & 1);
    end
    a = ba[0]; b = bb[0]; sub = bs[0]; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!done && c < 20);
      chk($sformatf("b2b%0d_gap", k), 64'(c), (k == 0) ? 64'd5 : 64'd6);
      model(ba[k], bb[k], bs[k], msum, mco, mov);
      chk($sformatf("b2b%0d_sum", k), sum, msum);
      chk($sformatf("b2b%0d_cout", k), {63'd0, cout}, {63'd0, mco});
      chk($sformatf("b2b%0d_ovf", k), {63'd0, ovf}, {63'd0, mov});
      if (k < 3) begin
        a = ba[k+1]; b = bb[k+1]; sub = bs[k+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("b2b_end_idle", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
